// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state
// encoding and the stable-time defaults for simulation and silicon.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_IDLE_HIGH = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    localparam int DB_CYCLES_SIM = 4;
    localparam int DB_CYCLES_HW  = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pins; clears to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;

    // Two-stage metastability filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/button_debounce.sv
// Push-button front end: synchronises the raw pin, accepts a new level only
// after it has been stable for DB_CYCLES, and emits press/release strobes.
module button_debounce
    import button_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_HW,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise,
    output logic btn_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             db_r;
    logic             rise_r;
    logic             fall_r;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (sync_s)
    );

    // Debounce FSM; strobes default low and pulse only on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE_LOW;
            cnt_r   <= '0;
            db_r    <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                ST_IDLE_LOW: begin
                    cnt_r <= '0;
                    if (sync_s) begin
                        state_r <= ST_WAIT_HIGH;
                    end else begin
                        state_r <= ST_IDLE_LOW;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sync_s) begin
                        state_r <= ST_IDLE_LOW;
                        cnt_r   <= '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE_HIGH;
                        cnt_r   <= '0;
                        db_r    <= 1'b1;
                        rise_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_IDLE_HIGH: begin
                    cnt_r <= '0;
                    if (!sync_s) begin
                        state_r <= ST_WAIT_LOW;
                    end else begin
                        state_r <= ST_IDLE_HIGH;
                    end
                end
                ST_WAIT_LOW: begin
                    if (sync_s) begin
                        state_r <= ST_IDLE_HIGH;
                        cnt_r   <= '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE_LOW;
                        cnt_r   <= '0;
                        db_r    <= 1'b0;
                        fall_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE_LOW;
                    cnt_r   <= '0;
                    db_r    <= 1'b0;
                end
            endcase
        end
    end

    assign btn_db   = db_r;
    assign btn_rise = rise_r;
    assign btn_fall = fall_r;

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioning stage for a raw mechanical push-button input.
- Synchronises the asynchronous pin into the clk domain and rejects contact bounce with a stable-time counter.
- Emits a clean level plus single-cycle press and release strobes.
- btn_db feeds the downstream one-shot stage, which takes a clean level and produces a single-cycle pulse.

Parameters:
- DB_CYCLES, 1000000, consecutive cycles the synchronised input must hold a new value before it is accepted (10 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(DB_CYCLES), width of the stability counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; synchronous deassertion handled at top level.
- btn_raw  input  1  raw button pin, asynchronous, bouncing.
- btn_db  output  1  debounced level, registered.
- btn_rise  output  1  one-cycle strobe on accepted 0->1 of btn_db.
- btn_fall  output  1  one-cycle strobe on accepted 1->0 of btn_db.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync flops s1, s2 = 0; state = IDLE_LOW; cnt = 0.
  - btn_db = 0, btn_rise = 0, btn_fall = 0.
  - Reset mid-bounce or mid-count discards all progress, with no strobe.
- Synchroniser: btn_raw -> s1 -> s2, two flops. s2 is the only signal the FSM observes.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - s2=1 -> WAIT_HIGH, cnt<=0.
  - Otherwise stay.
- WAIT_HIGH:
  - s2=0 -> IDLE_LOW, cnt<=0 (bounce rejected, no output change).
  - s2=1 and cnt==DB_CYCLES-1 -> IDLE_HIGH, btn_db<=1, btn_rise<=1.
  - s2=1 otherwise -> cnt<=cnt+1.
- IDLE_HIGH and WAIT_LOW: mirror images of the above, driving btn_db<=0 and btn_fall<=1.
- Strobes:
  - btn_rise and btn_fall are registered and high for exactly one cycle, on the same edge btn_db changes.
  - Both are 0 in every other cycle and are never high together.
- Latency: btn_raw changes before edge k and stays stable -> btn_db and the strobe update at edge k+2+DB_CYCLES. For DB_CYCLES=4 this is 6 edges after the sampling edge.
- Counter:
  - Saturation not needed; cnt never exceeds DB_CYCLES-1.
  - cnt is cleared on every entry to a WAIT state and on every state exit.
- Glitches shorter than DB_CYCLES+1 cycles (as seen at s2) never change btn_db.
- Button held during reset release: treated as a new press, producing one btn_rise after the full latency.
- Input toggling every cycle indefinitely: btn_db holds its value, no strobes.

Decomposition:
- Shared package button_pkg:
  - state enum/localparams ST_IDLE_LOW=2'd0, ST_WAIT_HIGH=2'd1, ST_IDLE_HIGH=2'd2, ST_WAIT_LOW=2'd3.
  - Default DB_CYCLES constant for simulation (4) and for hardware (1000000).
- Sub-module sync_2ff:
  - Generic 2-flop synchroniser with async active-low reset and reset value 0.
  - Reused by other pin inputs.

Test Plan (DB_CYCLES=4 unless stated):
- Reset: rst_n=0 with btn_raw toggling -> btn_db, btn_rise and btn_fall all 0 throughout. Asserting rst_n mid-WAIT_HIGH -> outputs stay 0 after release.
- Clean press: btn_raw 0->1 before edge 10 and held -> btn_db=1 and btn_rise=1 at edge 16; btn_rise=0 at edge 17; btn_fall never asserted.
- Bounce: btn_raw toggles 1,0,1,0 on edges 10..13, then held 1 -> no strobe until 6 edges after the last 0->1 sample, then a single btn_rise.
- Short glitch: 3-cycle high pulse on btn_raw from IDLE_LOW -> btn_db stays 0, no strobes.
- Release: from btn_db=1, btn_raw 1->0 held -> btn_fall pulse for one cycle at latency 6, btn_db=0. Press/release counts over 20 random bounced presses are equal.
- Held at reset: btn_raw=1 during reset, rst_n released at edge 5 -> exactly one btn_rise, at edge 11.
